// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg
//   Shared definitions for the branch-prediction redirect controller:
//   default PC width, FSM state encoding, queue entry width helper and the
//   PC-select constants that give pre_jump / res_taken their meaning.
package pc_redirect_ctrl_pkg;

    localparam int WIDTH_PC = 32;

    // Meaning of pre_jump / res_taken: 0 selects pc+4, 1 selects the jump target.
    localparam logic PCSEL_PC4  = 1'b0;
    localparam logic PCSEL_JUMP = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Queue entry layout, MSB first: {pc, pre_jump, pre_pc}.
    function automatic int entry_w(input int width_pc);
        return 2 * width_pc + 1;
    endfunction

    localparam int ENTRY_W = entry_w(WIDTH_PC);

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// pc_redirect_ctrl_if
//   Fetch / resolve / redirect signals between IF, EX and the redirect
//   controller.
//   master : the pipeline side (drives fetch and resolution, receives redirect)
//   slave  : the controller side
interface pc_redirect_ctrl_if #(
    parameter int WIDTH_PC = pc_redirect_ctrl_pkg::WIDTH_PC
);
    // IF -> controller: one predicted instruction
    logic                fetch_valid;
    logic [WIDTH_PC-1:0] fetch_pc;
    logic                pre_jump;
    logic [WIDTH_PC-1:0] pre_pc;
    // EX -> controller: resolution of the oldest in-flight instruction
    logic                res_valid;
    logic                res_taken;
    logic [WIDTH_PC-1:0] res_target;
    // controller -> pipeline
    logic                flush;
    logic                redirect_valid;
    logic [WIDTH_PC-1:0] redirect_pc;
    logic                stop_fetch;

    modport master (
        output fetch_valid, fetch_pc, pre_jump, pre_pc,
        output res_valid, res_taken, res_target,
        input  flush, redirect_valid, redirect_pc, stop_fetch
    );

    modport slave (
        input  fetch_valid, fetch_pc, pre_jump, pre_pc,
        input  res_valid, res_taken, res_target,
        output flush, redirect_valid, redirect_pc, stop_fetch
    );
endinterface

// File: rtl/pc_redirect_ctrl_pred_queue.sv
// pc_redirect_ctrl_pred_queue
//   In-order FIFO of in-flight predictions.
//   push/pop : enqueue din / dequeue head (same cycle allowed, also when full)
//   clear    : empties the queue, overrides push and pop
//   head     : oldest entry (valid when !empty)
//   full, empty, count : registered occupancy; count_nxt is its next value
module pc_redirect_ctrl_pred_queue #(
    parameter int W     = 65,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full queue still accepts a push.
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;

    always_comb begin
        if (clear) count_nxt = '0;
        else       count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                // DEPTH is a power of two, so the pointers wrap naturally.
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // NOTE: storage is deliberately not reset; an entry is never read before
    // it is written because occupancy is reset, and this keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Checks every predicted fetch against its execute-stage resolution. On a
//   mispredict it issues a one-cycle flush + PC redirect, then holds fetch for
//   REFILL_CYCLES further cycles.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : fetch/resolve inputs, flush/redirect/stop_fetch outputs
//   inflight        : queue occupancy
//   mispredict_cnt  : saturating mispredict count
//   protocol_err    : sticky; push while full (no pop) or resolve while empty
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int WIDTH_PC      = pc_redirect_ctrl_pkg::WIDTH_PC,
    parameter int DEPTH         = 4,
    parameter int REFILL_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pc_redirect_ctrl_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic [CNT_W-1:0]             mispredict_cnt,
    output logic                         protocol_err
);
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int EW      = entry_w(WIDTH_PC);
    localparam int DRAIN_W = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 flush_q, flush_d;
    logic                 rv_q, rv_d;
    logic                 stop_q, stop_d;
    logic [WIDTH_PC-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 perr_q, perr_d;

    logic [EW-1:0]        q_head;
    logic                 q_full, q_empty;
    logic [OCC_W-1:0]     q_count, q_count_nxt;

    logic [WIDTH_PC-1:0]  head_pc, head_pre_pc, correct_pc;
    logic                 head_pre_jump;
    logic                 run, pop_req, push_req, mismatch, push_err, pop_err;

    assign {head_pc, head_pre_jump, head_pre_pc} = q_head;

    assign run      = (state_q == ST_RUN);
    assign pop_req  = run & bus.res_valid & ~q_empty;
    assign mismatch = pop_req &
                      ((bus.res_taken != head_pre_jump) |
                       (bus.res_taken & (bus.res_target != head_pre_pc)));
    // Anything fetched alongside a mispredicted resolution is wrong-path.
    assign push_req = run & bus.fetch_valid & ~mismatch;
    assign push_err = push_req & q_full & ~pop_req;
    assign pop_err  = run & bus.res_valid & q_empty;

    assign correct_pc = (bus.res_taken == PCSEL_JUMP) ? bus.res_target
                                                      : head_pc + WIDTH_PC'(4);

    pc_redirect_ctrl_pred_queue #(
        .W     (EW),
        .DEPTH (DEPTH),
        .CW    (OCC_W)
    ) u_pred_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .pop       (pop_req),
        .clear     (state_q == ST_FLUSH),
        .din       ({bus.fetch_pc, bus.pre_jump, bus.pre_pc}),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .count_nxt (q_count_nxt)
    );

    // Outputs are computed for the next state so they come straight from flops.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d       = state_q;
        drain_d       = drain_q;
        flush_d       = 1'b0;
        rv_d          = 1'b0;
        stop_d        = 1'b0;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        perr_d        = perr_q;

        unique case (state_q)
            ST_RUN: begin
                stop_d = (q_count_nxt == OCC_W'(DEPTH));
                if (push_err | pop_err) perr_d = 1'b1;
                if (mismatch) begin
                    state_d       = ST_FLUSH;
                    flush_d       = 1'b1;
                    rv_d          = 1'b1;
                    stop_d        = 1'b1;
                    redirect_pc_d = correct_pc;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_DRAIN;
                drain_d = DRAIN_W'(REFILL_CYCLES - 1);
                stop_d  = 1'b1;
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                    stop_d  = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            drain_q       <= '0;
            flush_q       <= 1'b0;
            rv_q          <= 1'b0;
            stop_q        <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
            perr_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            flush_q       <= flush_d;
            rv_q          <= rv_d;
            stop_q        <= stop_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
            perr_q        <= perr_d;
        end
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.stop_fetch     = stop_q;
    assign inflight           = q_count;
    assign mispredict_cnt     = cnt_q;
    assign protocol_err       = perr_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl
//   Directed self-checking bench for pc_redirect_ctrl (DEPTH=4, REFILL_CYCLES=2).
//   Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_pc_redirect_ctrl;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  inflight;
    logic [15:0] mispredict_cnt;
    logic        protocol_err;

    int tests = 0;
    int fails = 0;

    pc_redirect_ctrl_if #(.WIDTH_PC(W)) bus ();

    pc_redirect_ctrl #(
        .WIDTH_PC      (W),
        .DEPTH         (4),
        .REFILL_CYCLES (2),
        .CNT_W         (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .inflight       (inflight),
        .mispredict_cnt (mispredict_cnt),
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [W-1:0] fpc, input logic pj,
                         input logic [W-1:0] ppc, input logic rv, input logic rt,
                         input logic [W-1:0] rtgt);
        bus.fetch_valid = fv;
        bus.fetch_pc    = fpc;
        bus.pre_jump    = pj;
        bus.pre_pc      = ppc;
        bus.res_valid   = rv;
        bus.res_taken   = rt;
        bus.res_target  = rtgt;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Bounded wait for fetch to be released after a recovery.
    task automatic wait_run(input string name);
        int n = 0;
        while (bus.stop_fetch && n < 10) begin
            tick();
            n++;
        end
        tests++;
        if (bus.stop_fetch !== 1'b0) begin
            $display("FAIL %s_wait_run: stop_fetch still %b after %0d cycles", name, bus.stop_fetch, n);
            fails++;
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        tests++;
        if ({bus.flush, bus.redirect_valid, bus.stop_fetch, protocol_err} !== 4'b0 ||
            bus.redirect_pc !== '0 || inflight !== 3'd0 || mispredict_cnt !== 16'd0) begin
            $display("FAIL reset: flush=%b rv=%b stop=%b perr=%b rpc=%h infl=%0d cnt=%0d, want all 0",
                     bus.flush, bus.redirect_valid, bus.stop_fetch, protocol_err,
                     bus.redirect_pc, inflight, mispredict_cnt);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_correct_predictions();
        int flushes = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(32'h100 + 4 * i), 1'b0, W'(32'h104 + 4 * i), 1'b0, 1'b0, '0);
            tick();
        end
        idle();
        tests++;
        if (inflight !== 3'd4 || bus.stop_fetch !== 1'b1) begin
            $display("FAIL correct_fill: inflight=%0d stop=%b, want 4/1", inflight, bus.stop_fetch);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
            tick();
            if (bus.flush) flushes++;
        end
        idle();
        tick();
        if (bus.flush) flushes++;
        tests++;
        if (flushes != 0 || inflight !== 3'd0 || mispredict_cnt !== 16'd0 || bus.stop_fetch !== 1'b0) begin
            $display("FAIL correct_drain: flushes=%0d inflight=%0d cnt=%0d stop=%b, want 0/0/0/0",
                     flushes, inflight, mispredict_cnt, bus.stop_fetch);
            fails++;
        end
    endtask

    task automatic test_direction_mispredict();
        int stops = 0;
        drive(1'b1, 32'h200, 1'b0, 32'h204, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h400);
        tick();
        idle();
        tests++;
        if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h400 ||
            mispredict_cnt !== 16'd1) begin
            $display("FAIL dir_flush: flush=%b rv=%b rpc=%h cnt=%0d, want 1/1/00000400/1",
                     bus.flush, bus.redirect_valid, bus.redirect_pc, mispredict_cnt);
            fails++;
        end
        while (bus.stop_fetch && stops < 10) begin
            stops++;
            tick();
            tests++;
            if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
                $display("FAIL dir_pulse: flush=%b rv=%b after FLUSH, want 0/0", bus.flush, bus.redirect_valid);
                fails++;
            end
        end
        tests++;
        if (stops != 3 || bus.redirect_pc !== 32'h400) begin
            $display("FAIL dir_stop_len: stop cycles=%0d rpc=%h, want 3/00000400", stops, bus.redirect_pc);
            fails++;
        end
    endtask

    task automatic test_target_mispredict_push();
        drive(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 32'h304, 1'b0, 32'h308, 1'b1, 1'b1, 32'h508);
        tick();
        idle();
        tests++;
        if (bus.flush !== 1'b1 || bus.redirect_pc !== 32'h508 || mispredict_cnt !== 16'd2) begin
            $display("FAIL tgt_flush: flush=%b rpc=%h cnt=%0d, want 1/00000508/2",
                     bus.flush, bus.redirect_pc, mispredict_cnt);
            fails++;
        end
        tick();
        tests++;
        if (inflight !== 3'd0 || bus.stop_fetch !== 1'b1) begin
            $display("FAIL tgt_after_flush: inflight=%0d stop=%b, want 0/1", inflight, bus.stop_fetch);
            fails++;
        end
        wait_run("tgt");
    endtask

    task automatic test_not_taken_wrap();
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1000, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h1234);
        tick();
        idle();
        tests++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0 || mispredict_cnt !== 16'd3) begin
            $display("FAIL wrap: rv=%b rpc=%h cnt=%0d, want 1/00000000/3",
                     bus.redirect_valid, bus.redirect_pc, mispredict_cnt);
            fails++;
        end
        wait_run("wrap");
    endtask

    task automatic test_full_queue();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(32'h600 + 4 * i), 1'b0, '0, 1'b0, 1'b0, '0);
            tick();
        end
        tests++;
        if (bus.stop_fetch !== 1'b1 || inflight !== 3'd4) begin
            $display("FAIL full_fill: stop=%b inflight=%0d, want 1/4", bus.stop_fetch, inflight);
            fails++;
        end
        drive(1'b1, 32'h610, 1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        tests++;
        if (inflight !== 3'd4 || protocol_err !== 1'b0 || bus.flush !== 1'b0) begin
            $display("FAIL full_push_pop: inflight=%0d perr=%b flush=%b, want 4/0/0",
                     inflight, protocol_err, bus.flush);
            fails++;
        end
        drive(1'b1, 32'h614, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        tests++;
        if (inflight !== 3'd4 || protocol_err !== 1'b1) begin
            $display("FAIL full_overflow: inflight=%0d perr=%b, want 4/1", inflight, protocol_err);
            fails++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
            tick();
        end
        idle();
        tick();
        tests++;
        if (inflight !== 3'd0 || protocol_err !== 1'b1 || mispredict_cnt !== 16'd3 || bus.stop_fetch !== 1'b0) begin
            $display("FAIL full_drain: inflight=%0d perr=%b cnt=%0d stop=%b, want 0/1/3/0",
                     inflight, protocol_err, mispredict_cnt, bus.stop_fetch);
            fails++;
        end
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b1, 32'h700, 1'b0, 32'h704, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h800);
        tick();
        idle();
        tick();
        tests++;
        if (bus.stop_fetch !== 1'b1 || bus.flush !== 1'b0 || bus.redirect_pc !== 32'h800) begin
            $display("FAIL drain_enter: stop=%b flush=%b rpc=%h, want 1/0/00000800",
                     bus.stop_fetch, bus.flush, bus.redirect_pc);
            fails++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.flush, bus.redirect_valid, bus.stop_fetch, protocol_err} !== 4'b0 ||
            bus.redirect_pc !== '0 || inflight !== 3'd0 || mispredict_cnt !== 16'd0) begin
            $display("FAIL async_reset: flush=%b rv=%b stop=%b perr=%b rpc=%h infl=%0d cnt=%0d, want all 0",
                     bus.flush, bus.redirect_valid, bus.stop_fetch, protocol_err,
                     bus.redirect_pc, inflight, mispredict_cnt);
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'h900, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        idle();
        tests++;
        if (inflight !== 3'd1 || bus.stop_fetch !== 1'b0 || mispredict_cnt !== 16'd0) begin
            $display("FAIL run_after_reset: inflight=%0d stop=%b cnt=%0d, want 1/0/0",
                     inflight, bus.stop_fetch, mispredict_cnt);
            fails++;
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        idle();
    endtask

    task automatic test_resolve_empty();
        tests++;
        if (inflight !== 3'd0 || protocol_err !== 1'b0) begin
            $display("FAIL empty_pre: inflight=%0d perr=%b, want 0/0", inflight, protocol_err);
            fails++;
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hABC);
        tick();
        idle();
        tests++;
        if (protocol_err !== 1'b1 || bus.flush !== 1'b0 || inflight !== 3'd0 || mispredict_cnt !== 16'd0) begin
            $display("FAIL empty_resolve: perr=%b flush=%b inflight=%0d cnt=%0d, want 1/0/0/0",
                     protocol_err, bus.flush, inflight, mispredict_cnt);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_correct_predictions();
        test_direction_mispredict();
        test_target_mispredict_push();
        test_not_taken_wrap();
        test_full_queue();
        test_reset_mid_drain();
        test_resolve_empty();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
